// File: rtl/add_accum_if.sv
// Operand/result handshake bundle for add_accum_unit: one valid/ready pair
// toward the unit and one away from it, plus status outputs.
interface add_accum_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [1:0]           mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic                 carry;
  logic                 overflow;
  logic [WIDTH-1:0]     acc_value;
  logic [CNT_WIDTH-1:0] txn_count;

  modport master (
    output in_valid, op_a, op_b, mode, out_ready,
    input  in_ready, out_valid, result, carry, overflow, acc_value, txn_count
  );

  modport slave (
    input  in_valid, op_a, op_b, mode, out_ready,
    output in_ready, out_valid, result, carry, overflow, acc_value, txn_count
  );
endinterface

// File: rtl/add_accum_unit.sv
// Registered add/sub/accumulate/load unit with a single output stage,
// carry/borrow and signed-overflow flags, accumulator and transaction counter.
module add_accum_unit #(
  parameter int WIDTH     = 8,
  parameter int SATURATE  = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  add_accum_if.slave  bus
);

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Sign rule: operands x and y (y already negated for SUB) overflow when
  // they share a sign that the sum does not.
  function automatic logic signed_ovf(input logic x_msb, input logic y_msb,
                                      input logic r_msb, input logic is_sub);
    logic y_eff;
    y_eff = is_sub ? ~y_msb : y_msb;
    return (x_msb == y_eff) && (r_msb != x_msb);
  endfunction

  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q,    result_d;
  logic                 carry_q,     carry_d;
  logic                 overflow_q,  overflow_d;
  logic [WIDTH-1:0]     acc_q,       acc_d;
  logic [CNT_WIDTH-1:0] cnt_q,       cnt_d;

  logic                 in_ready_s;
  logic                 accept_s;
  logic [WIDTH:0]       raw_s;
  logic [WIDTH-1:0]     res_s;
  logic                 carry_s;
  logic                 ovf_s;

  assign in_ready_s = !out_valid_q || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;

  // Datapath: WIDTH+1-bit raw result, flags and optional clamping.
  always_comb begin
    raw_s   = {1'b0, bus.op_a};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    res_s   = bus.op_a;
    case (bus.mode)
      MODE_ADD: begin
        raw_s   = {1'b0, bus.op_a} + {1'b0, bus.op_b};
        carry_s = raw_s[WIDTH];
        ovf_s   = signed_ovf(bus.op_a[WIDTH-1], bus.op_b[WIDTH-1], raw_s[WIDTH-1], 1'b0);
      end
      MODE_SUB: begin
        raw_s   = {1'b0, bus.op_a} - {1'b0, bus.op_b};
        carry_s = raw_s[WIDTH];
        ovf_s   = signed_ovf(bus.op_a[WIDTH-1], bus.op_b[WIDTH-1], raw_s[WIDTH-1], 1'b1);
      end
      MODE_ACC: begin
        raw_s   = {1'b0, acc_q} + {1'b0, bus.op_a};
        carry_s = raw_s[WIDTH];
        ovf_s   = signed_ovf(acc_q[WIDTH-1], bus.op_a[WIDTH-1], raw_s[WIDTH-1], 1'b0);
      end
      MODE_LOAD: begin
        raw_s   = {1'b0, bus.op_a};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
      default: begin
        raw_s   = {1'b0, bus.op_a};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
    endcase

    if ((SATURATE != 0) && carry_s && (bus.mode == MODE_SUB)) begin
      res_s = {WIDTH{1'b0}};
    end else if ((SATURATE != 0) && carry_s) begin
      res_s = {WIDTH{1'b1}};
    end else begin
      res_s = raw_s[WIDTH-1:0];
    end
  end

  // Next state: accept (possibly replacing a result being consumed), drain, or hold.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      result_d    = res_s;
      carry_d     = carry_s;
      overflow_d  = ovf_s;
      cnt_d       = cnt_q + CNT_WIDTH'(1);
      if ((bus.mode == MODE_ACC) || (bus.mode == MODE_LOAD)) begin
        acc_d = res_s;
      end else begin
        acc_d = acc_q;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      acc_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_WIDTH{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.acc_value = acc_q;
  assign bus.txn_count = cnt_q;

endmodule

// File: tb/tb_add_accum_unit.sv
// Drives a wrapping/16-bit-counter unit and a saturating/4-bit-counter unit
// with identical stimulus and compares both against an arithmetic reference.
module tb_add_accum_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  add_accum_if #(.WIDTH(8), .CNT_WIDTH(16)) if0 ();
  add_accum_if #(.WIDTH(8), .CNT_WIDTH(4))  if1 ();

  add_accum_unit #(.WIDTH(8), .SATURATE(0), .CNT_WIDTH(16)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  add_accum_unit #(.WIDTH(8), .SATURATE(1), .CNT_WIDTH(4))  dut1 (.clk(clk), .rst(rst), .bus(if1));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state, index 0 = wrapping unit, 1 = saturating unit
  bit m_valid [2];
  int m_res   [2];
  int m_cy    [2];
  int m_ov    [2];
  int m_acc   [2];
  int m_cnt   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic model_op(input int k, input int md, input int a, input int b);
    int raw, sraw, cy, res;
    bit sat;
    sat = (k == 1);
    res = 0; cy = 0; sraw = 0;
    case (md)
      0: begin
        raw = a + b; cy = (raw > 255) ? 1 : 0; sraw = sgn8(a) + sgn8(b);
        res = (sat && cy == 1) ? 255 : raw % 256;
      end
      1: begin
        raw = a - b; cy = (a < b) ? 1 : 0; sraw = sgn8(a) - sgn8(b);
        res = (sat && cy == 1) ? 0 : (raw + 256) % 256;
      end
      2: begin
        raw = m_acc[k] + a; cy = (raw > 255) ? 1 : 0; sraw = sgn8(m_acc[k]) + sgn8(a);
        res = (sat && cy == 1) ? 255 : raw % 256;
        m_acc[k] = res;
      end
      default: begin
        res = a; cy = 0; sraw = 0; m_acc[k] = a;
      end
    endcase
    m_res[k] = res;
    m_cy[k]  = cy;
    m_ov[k]  = (sraw < -128 || sraw > 127) ? 1 : 0;
  endtask

  // One clock: drive inputs, check in_ready, advance the reference, check outputs.
  task automatic step(input bit r, input bit v, input bit [1:0] md,
                      input bit [7:0] a, input bit [7:0] b, input bit ordy);
    bit rdy;
    rst = r;
    if0.in_valid = v; if0.mode = md; if0.op_a = a; if0.op_b = b; if0.out_ready = ordy;
    if1.in_valid = v; if1.mode = md; if1.op_a = a; if1.op_b = b; if1.out_ready = ordy;
    #1;
    chk("in_ready0", 32'(if0.in_ready), 32'(!m_valid[0] || ordy));
    chk("in_ready1", 32'(if1.in_ready), 32'(!m_valid[1] || ordy));
    for (int k = 0; k < 2; k++) begin
      rdy = !m_valid[k] || ordy;
      if (r) begin
        m_valid[k] = 1'b0; m_res[k] = 0; m_cy[k] = 0; m_ov[k] = 0; m_acc[k] = 0; m_cnt[k] = 0;
      end else if (v && rdy) begin
        model_op(k, int'(md), int'(a), int'(b));
        m_valid[k] = 1'b1;
        m_cnt[k]++;
      end else if (ordy) begin
        m_valid[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid0", 32'(if0.out_valid), 32'(m_valid[0]));
    chk("result0",    32'(if0.result),    m_res[0]);
    chk("carry0",     32'(if0.carry),     m_cy[0]);
    chk("overflow0",  32'(if0.overflow),  m_ov[0]);
    chk("acc0",       32'(if0.acc_value), m_acc[0]);
    chk("txn0",       32'(if0.txn_count), m_cnt[0] % 65536);
    chk("out_valid1", 32'(if1.out_valid), 32'(m_valid[1]));
    chk("result1",    32'(if1.result),    m_res[1]);
    chk("carry1",     32'(if1.carry),     m_cy[1]);
    chk("overflow1",  32'(if1.overflow),  m_ov[1]);
    chk("acc1",       32'(if1.acc_value), m_acc[1]);
    chk("txn1",       32'(if1.txn_count), m_cnt[1] % 16);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0; m_res[k] = 0; m_cy[k] = 0; m_ov[k] = 0; m_acc[k] = 0; m_cnt[k] = 0;
    end

    // Reset then idle
    step(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    chk("rst_in_ready", 32'(if0.in_ready), 32'd1);
    chk("rst_result",   32'(if0.result),   32'd0);

    // ADD with wrap, then signed overflow
    step(1'b0, 1'b1, 2'b00, 8'hF0, 8'h20, 1'b1);
    chk("add_res",   32'(if0.result),   32'h10);
    chk("add_carry", 32'(if0.carry),    32'd1);
    chk("add_ovf",   32'(if0.overflow), 32'd0);
    step(1'b0, 1'b1, 2'b00, 8'h70, 8'h10, 1'b1);
    chk("add2_res", 32'(if0.result),   32'h80);
    chk("add2_ovf", 32'(if0.overflow), 32'd1);

    // Saturating SUB and ADD
    step(1'b0, 1'b1, 2'b01, 8'h05, 8'h09, 1'b1);
    chk("satsub_res",   32'(if1.result), 32'h00);
    chk("satsub_carry", 32'(if1.carry),  32'd1);
    chk("wrapsub_res",  32'(if0.result), 32'hFC);
    step(1'b0, 1'b1, 2'b00, 8'hFF, 8'h02, 1'b1);
    chk("satadd_res", 32'(if1.result), 32'hFF);

    // LOAD then three ACCs
    step(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
    step(1'b0, 1'b1, 2'b11, 8'h10, 8'h77, 1'b1);
    chk("load_acc", 32'(if0.acc_value), 32'h10);
    step(1'b0, 1'b1, 2'b10, 8'h05, 8'h00, 1'b1);
    chk("acc_1", 32'(if0.acc_value), 32'h15);
    step(1'b0, 1'b1, 2'b10, 8'h05, 8'h00, 1'b1);
    chk("acc_2", 32'(if0.acc_value), 32'h1A);
    step(1'b0, 1'b1, 2'b10, 8'h05, 8'h00, 1'b1);
    chk("acc_3", 32'(if0.acc_value), 32'h1F);
    chk("acc_txn", 32'(if0.txn_count), 32'd4);

    // Back-pressure, then consume-and-accept on one edge
    step(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
    step(1'b0, 1'b1, 2'b00, 8'h01, 8'h02, 1'b0);
    step(1'b0, 1'b1, 2'b00, 8'h07, 8'h07, 1'b0);
    step(1'b0, 1'b1, 2'b00, 8'h07, 8'h07, 1'b0);
    chk("bp_frozen", 32'(if0.result), 32'h03);
    step(1'b0, 1'b1, 2'b00, 8'h07, 8'h07, 1'b1);
    chk("bp_swap_res",   32'(if0.result),    32'h0E);
    chk("bp_swap_valid", 32'(if0.out_valid), 32'd1);

    // Reset mid-stream with a pending op
    step(1'b1, 1'b1, 2'b10, 8'h44, 8'h00, 1'b0);
    chk("mid_rst_valid", 32'(if0.out_valid), 32'd0);
    chk("mid_rst_txn",   32'(if0.txn_count), 32'd0);

    // Counter wrap on the 4-bit unit
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 2'b00, 8'(i), 8'h01, 1'b1);
    end
    chk("wrap_txn4",  32'(if1.txn_count), 32'd1);
    chk("wrap_txn16", 32'(if0.txn_count), 32'd17);

    // Randomised traffic against the reference
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/add_accum_unit.md
Name: add_accum_unit

Overview:
Parametrised, registered successor to the combinational 8-bit pin adder. Accepts operand pairs over a valid/ready handshake and performs ADD, SUB, ACCUMULATE or LOAD. Presents a registered result with carry/borrow and signed-overflow flags. Sits between the pin-level input bytes and the output byte in the top-level wrapper, and also keeps a running accumulator and a transaction count.

Parameters:
WIDTH, 8, operand/result/accumulator width in bits (>=2)
SATURATE, 0, 1 = clamp results to unsigned range; 0 = wrap modulo 2^WIDTH
CNT_WIDTH, 16, width of the accepted-transaction counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand/mode presented this cycle
in_ready  output  1  unit can accept an operation this cycle
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B (ignored for ACC/LOAD)
mode  input  2  00 ADD a+b, 01 SUB a-b, 10 ACC acc+a, 11 LOAD acc<=a
out_valid  output  1  result register holds an unconsumed result
out_ready  input  1  consumer takes result this cycle
result  output  WIDTH  registered result
carry  output  1  ADD/ACC: unsigned carry-out; SUB: borrow (a<b); LOAD: 0
overflow  output  1  signed two's-complement overflow of the unsaturated result; LOAD: 0
acc_value  output  WIDTH  current accumulator contents
txn_count  output  CNT_WIDTH  number of accepted operations, wraps

Behaviour:
- Reset (rst=1 at a clk edge) clears all outputs and state:
  - out_valid=0, result=0, carry=0, overflow=0, acc_value=0, txn_count=0.
  - rst overrides any handshake in the same cycle.
  - Reset mid-operation discards the pending result.
- in_ready = !out_valid || out_ready. This is combinational, with a single output stage.
- Accept condition: in_valid && in_ready at the edge. Latency is 1 cycle: result, flags and out_valid=1 appear the cycle after acceptance.
- Simultaneous consume and accept (out_valid && out_ready && in_valid): the new result replaces the old one in the same edge, and out_valid stays 1. Full throughput is 1 op/cycle.
- Consume without accept: out_valid goes to 0. result and flags hold their last values.
- While out_valid=1 && out_ready=0: result, flags and acc_value are stable, and no operation is accepted.
- Arithmetic is computed at WIDTH+1 bits.
  - ADD: raw = a+b, carry = raw[WIDTH].
  - SUB: raw = a-b, carry = borrow.
  - ACC: raw = acc+a, carry = raw[WIDTH].
  - overflow follows the standard sign rule on WIDTH-bit operands.
- SATURATE=1:
  - ADD/ACC with carry -> result = all ones.
  - SUB with borrow -> result = 0.
  - Flags still report the raw event.
- SATURATE=0: result = raw[WIDTH-1:0].
- Accumulator updates on accepted ops only:
  - ACC: acc <= result (post-saturation).
  - LOAD: acc <= a; result = a; carry = 0; overflow = 0.
  - ADD/SUB leave acc unchanged.
- acc_value reflects the update from the same edge that loads result.
- txn_count increments by 1 on every accept and wraps from 2^CNT_WIDTH-1 to 0.
- Top-level wrapper mapping (outside this block):
  - ui_in -> op_a, uio_in -> op_b, uo_out <- result.
  - Unused IOs are tied per the existing wrapper.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, result=0, acc_value=0, txn_count=0, in_ready=1.
- ADD WIDTH=8, SATURATE=0: a=0xF0, b=0x20 -> next cycle result=0x10, carry=1, overflow=0, out_valid=1. Then a=0x70, b=0x10 -> result=0x80, carry=0, overflow=1.
- SUB and saturation with SATURATE=1: a=0x05, b=0x09 SUB -> result=0x00, carry=1. ADD a=0xFF, b=0x02 -> result=0xFF, carry=1.
- Accumulate: LOAD a=0x10, then ACC a=0x05 three times with out_ready=1 -> acc_value 0x10, 0x15, 0x1A, 0x1F on consecutive cycles, txn_count=4.
- Back-pressure: out_ready=0 after one result, in_valid held -> in_ready=0 and result frozen. Raising out_ready for 1 cycle -> old result consumed and new op accepted on the same edge, out_valid stays 1.
- Reset mid-stream: rst asserted while out_valid=1 and in_valid=1 -> next cycle out_valid=0, acc_value=0, txn_count=0, and the op is not counted. Also: txn_count with CNT_WIDTH=4 after 17 accepts = 1.
